// File: rtl/dmem_arb_pkg.sv
// Shared types and limits for the two-port data-RAM arbiter.
// Holds the read-tag format carried down the read-latency pipeline.
package dmem_arb_pkg;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } tag_t;

   localparam int RD_LAT_MIN    = 1;
   localparam int RD_LAT_MAX    = 4;
   localparam int MAX_A_RUN_MIN = 1;
   localparam int MAX_A_RUN_MAX = 255;
   localparam int RUN_CNT_W     = 8;

   localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_A};

endpackage

// File: rtl/dmem_arb_tagpipe.sv
// Fixed-depth shift register of read tags; the tail lines up with the RAM's
// read data so each returning word can be steered to the port that asked for it.
module dmem_arb_tagpipe
   import dmem_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  tag_t tag_in,
   output tag_t tag_out
);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      tag_t stage_reg;
      if (gi == 0) begin : g_head
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stage_reg <= TAG_IDLE;
            else        stage_reg <= tag_in;
         end
      end else begin : g_body
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stage_reg <= TAG_IDLE;
            else        stage_reg <= g_stage[gi-1].stage_reg;
         end
      end
   end

   assign tag_out = g_stage[DEPTH-1].stage_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data RAM (A = CPU, B = secondary).
// Define DMEM_ARB_STARVE_GUARD_EN to bound how long A may lock out a waiting B.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int RD_LAT    = 1,
   parameter int MAX_A_RUN = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q
);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("dmem_arbiter: RD_LAT out of range");
   end
   if (MAX_A_RUN < MAX_A_RUN_MIN || MAX_A_RUN > MAX_A_RUN_MAX) begin : g_bad_max_run
      $error("dmem_arbiter: MAX_A_RUN out of range");
   end

   logic              force_b;
   logic [ADDR_W-1:0] addr_hold_reg;
   tag_t              tag_in;
   tag_t              tag_tail;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   logic [RUN_CNT_W-1:0] run_cnt_reg;
   logic [RUN_CNT_W-1:0] run_cnt_next;

   // Only a B that is actually waiting can override A.
   assign force_b = b_req && (run_cnt_reg >= RUN_CNT_W'(MAX_A_RUN));

   always_comb begin
      run_cnt_next = run_cnt_reg;
      if (b_gnt || !b_req)
         run_cnt_next = '0;
      else if (a_gnt && run_cnt_reg != '1)
         run_cnt_next = run_cnt_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_cnt_reg <= '0;
      else        run_cnt_reg <= run_cnt_next;
   end
`else
   assign force_b = 1'b0;
`endif

   // Grants are suppressed while reset is held so nothing reaches the RAM.
   always_comb begin
      a_gnt = rst_n & a_req & ~force_b;
      b_gnt = rst_n & b_req & (~a_req | force_b);
   end

   always_comb begin
      ram_addr  = addr_hold_reg;
      ram_wdata = '0;
      ram_we    = 1'b0;
      if (a_gnt) begin
         ram_addr  = a_addr;
         ram_wdata = a_wdata;
         ram_we    = a_we;
      end else if (b_gnt) begin
         ram_addr  = b_addr;
         ram_wdata = b_wdata;
         ram_we    = b_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) addr_hold_reg <= '0;
      else        addr_hold_reg <= ram_addr;
   end

   always_comb begin
      tag_in       = TAG_IDLE;
      tag_in.valid = (a_gnt & ~a_we) | (b_gnt & ~b_we);
      tag_in.owner = b_gnt ? OWN_B : OWN_A;
   end

   dmem_arb_tagpipe #(
      .DEPTH (RD_LAT)
   ) u_tagpipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (tag_in),
      .tag_out (tag_tail)
   );

   assign a_rvalid = tag_tail.valid && (tag_tail.owner == OWN_A);
   assign b_rvalid = tag_tail.valid && (tag_tail.owner == OWN_B);
   assign a_rdata  = ram_q;
   assign b_rdata  = ram_q;

endmodule
